// File: rtl/prg_health_packer_if.sv
// ---------------------------------------------------------------------------
// prg_health_packer_if
//   Data-path bundle between the random bit source, the packer and the
//   byte consumer.
//   bit_in / bit_valid : raw generator bit and its qualifier
//   byte_out           : packed byte (first received bit in bit 7)
//   byte_valid         : byte_out holds an unconsumed byte
//   byte_ready         : consumer accepts byte_out
//   Modports: slave = packer side, master = generator/consumer side.
// ---------------------------------------------------------------------------
interface prg_health_packer_if;
  logic       bit_in;
  logic       bit_valid;
  logic       byte_ready;
  logic [7:0] byte_out;
  logic       byte_valid;

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  byte_ready,
    output byte_out,
    output byte_valid
  );

  modport master (
    output bit_in,
    output bit_valid,
    output byte_ready,
    input  byte_out,
    input  byte_valid
  );
endinterface

// File: rtl/prg_health_packer.sv
// ---------------------------------------------------------------------------
// prg_health_packer
//   Packs a serial pseudo-random bit stream into bytes (first bit -> bit 7)
//   and runs two online health tests on the stream:
//     - repetition-count test (RCT): run of RCT_CUTOFF identical bits
//     - adaptive-proportion test (APT): APT_CUTOFF samples equal to the first
//       sample of an APT_WINDOW-sample window
//   Any raised failure flag discards newly completed bytes.
//
//   Build option: define PRG_HEALTH_APT_EN to build the APT. Without it no
//   APT logic exists and apt_fail is tied low.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : synchronous active-low reset
//   ena      : block enable; when low every input is ignored, state held
//   clr_fail : one-cycle pulse clearing flags and test counters
//   bus      : slave side of prg_health_packer_if (bit in / byte out)
//   rct_fail : sticky repetition-count failure
//   apt_fail : sticky adaptive-proportion failure
//   overrun  : sticky, a completed byte was dropped because output was full
// ---------------------------------------------------------------------------
module prg_health_packer #(
  parameter int RCT_CUTOFF = 8,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       clr_fail,
  prg_health_packer_if.slave         bus,
  output logic                       rct_fail,
  output logic                       apt_fail,
  output logic                       overrun
);

  localparam logic [7:0] RCT_LIM = 8'(RCT_CUTOFF);

  // Only the low 7 bits of the shift register are ever needed: the 8th bit
  // arrives on the completing edge and goes straight into the output byte.
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic [7:0] run_q, run_d;
  logic       rct_q, rct_d;
  logic       ovr_q, ovr_d;
  logic       apt_d;

  logic       consume;
  logic       clr;
  logic       done;
  logic       xfer;
  logic       gate;
  logic [7:0] done_byte;

  assign consume   = ena & bus.bit_valid;
  assign clr       = ena & clr_fail;
  assign done      = consume & (cnt_q == 3'd7);
  assign done_byte = {shift_q, bus.bit_in};
  assign xfer      = ena & valid_q & bus.byte_ready;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    run_d   = run_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    ovr_d   = ovr_q & ~clr;
    gate    = 1'b0;

    if (consume) begin
      shift_d = done_byte[6:0];
      cnt_d   = cnt_q + 3'd1;
    end

    // Run counter: run_q == 0 means "no previous bit" (after reset/clear).
    // A clear coinciding with a bit makes that bit the start of a new run.
    if (consume) begin
      last_d = bus.bit_in;
      if (!clr && (run_q != 8'd0) && (bus.bit_in == last_q))
        run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      else
        run_d = 8'd1;
    end else if (clr) begin
      run_d = 8'd0;
    end

    rct_d = (rct_q & ~clr) | (consume & (run_d == RCT_LIM));

    // Gate on next-state flags so the byte completing on the very edge that
    // trips a test is also withheld.
    gate = rct_d | apt_d;

    if (xfer)
      valid_d = 1'b0;

    if (done && !gate) begin
      if (!valid_q || xfer) begin
        byte_d  = done_byte;
        valid_d = 1'b1;
      end else begin
        // A drop on the same edge as a clear is still reported.
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      run_q   <= '0;
      rct_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      run_q   <= run_d;
      rct_q   <= rct_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef PRG_HEALTH_APT_EN
  localparam int                WIN_W   = $clog2(APT_WINDOW + 1);
  localparam logic [WIN_W-1:0]  WIN_LEN = WIN_W'(APT_WINDOW);
  localparam logic [WIN_W-1:0]  APT_LIM = WIN_W'(APT_CUTOFF);

  // win_q == 0 means the window is not started; the next bit opens it.
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] match_q, match_d;
  logic             ref_q, ref_d;
  logic             apt_q;

  always_comb begin
    win_d   = win_q;
    match_d = match_q;
    ref_d   = ref_q;
    if (consume) begin
      if (clr || (win_q == '0) || (win_q == WIN_LEN)) begin
        ref_d   = bus.bit_in;
        win_d   = {{(WIN_W-1){1'b0}}, 1'b1};
        match_d = {{(WIN_W-1){1'b0}}, 1'b1};
      end else begin
        win_d = win_q + 1'b1;
        if (bus.bit_in == ref_q)
          match_d = match_q + 1'b1;
      end
    end else if (clr) begin
      win_d   = '0;
      match_d = '0;
    end
    apt_d = (apt_q & ~clr) | (consume & (match_d == APT_LIM));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q   <= '0;
      match_q <= '0;
      ref_q   <= 1'b0;
      apt_q   <= 1'b0;
    end else begin
      win_q   <= win_d;
      match_q <= match_d;
      ref_q   <= ref_d;
      apt_q   <= apt_d;
    end
  end

  assign apt_fail = apt_q;
`else
  // APT not built: window parameters only feed this sink.
  logic unused_apt_cfg;
  assign unused_apt_cfg = (APT_WINDOW >= APT_CUTOFF);
  assign apt_d    = 1'b0;
  assign apt_fail = 1'b0;
`endif

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign rct_fail       = rct_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_prg_health_packer.sv
module tb_prg_health_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic rst_n, ena, clr_fail;
  logic rct_fail, apt_fail, overrun;
  prg_health_packer_if pif();

  prg_health_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clr_fail (clr_fail),
    .bus      (pif),
    .rct_fail (rct_fail),
    .apt_fail (apt_fail),
    .overrun  (overrun)
  );

  // APT instance: RCT effectively disabled
  logic rst2_n, ena2, clr2;
  logic rct2, apt2, ovr2;
  prg_health_packer_if apif();

  prg_health_packer #(.RCT_CUTOFF(255)) dut_apt (
    .clk      (clk),
    .rst_n    (rst2_n),
    .ena      (ena2),
    .clr_fail (clr2),
    .bus      (apif),
    .rct_fail (rct2),
    .apt_fail (apt2),
    .overrun  (ovr2)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cycles   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

`ifdef PRG_HEALTH_APT_EN
  localparam logic APT_ON = 1'b1;
`else
  localparam logic APT_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock; any byte handed over on this edge is popped and compared.
  task automatic tick();
    logic       x1, x2;
    logic [7:0] b1, b2;
    x1 = rst_n && ena && pif.byte_valid && pif.byte_ready;
    b1 = pif.byte_out;
    x2 = rst2_n && ena2 && apif.byte_valid && apif.byte_ready;
    b2 = apif.byte_out;
    @(posedge clk);
    #1;
    cycles++;
    if (x1) begin
      if (exp_q.size() == 0) check("unexpected_byte", {24'd0, b1}, 32'hFFFF_FFFF);
      else check("xfer_byte", {24'd0, b1}, {24'd0, exp_q.pop_front()});
      $display("main xfer byte %02h", b1);
    end
    if (x2) begin
      if (exp2_q.size() == 0) check("apt_unexpected_byte", {24'd0, b2}, 32'hFFFF_FFFF);
      else check("apt_xfer_byte", {24'd0, b2}, {24'd0, exp2_q.pop_front()});
      $display("apt xfer byte %02h", b2);
    end
    if (cycles > 20000) begin
      $display("FAIL cycle_budget: observed %0d expected <= 20000", cycles);
      $fatal(1, "cycle budget exceeded");
    end
  endtask

  task automatic feed(input logic b);
    pif.bit_in    = b;
    pif.bit_valid = 1'b1;
    tick();
    pif.bit_valid = 1'b0;
  endtask

  task automatic feed_apt(input logic b);
    apif.bit_in    = b;
    apif.bit_valid = 1'b1;
    tick();
    apif.bit_valid = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] v, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) feed(v[i]);
  endtask

  task automatic pulse_clr();
    clr_fail = 1'b1;
    tick();
    clr_fail = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clr_fail = 1'b0;
    pif.bit_in = 1'b0; pif.bit_valid = 1'b0; pif.byte_ready = 1'b0;
    rst2_n = 1'b0; ena2 = 1'b1; clr2 = 1'b0;
    apif.bit_in = 1'b0; apif.bit_valid = 1'b0; apif.byte_ready = 1'b0;

    // reset state
    tick(); tick();
    rst_n = 1'b1;
    check("rst_byte_valid", pif.byte_valid, 1'b0);
    check("rst_byte_out", pif.byte_out, 8'h00);
    check("rst_rct", rct_fail, 1'b0);
    check("rst_apt", apt_fail, 1'b0);
    check("rst_ovr", overrun, 1'b0);

    // basic packing: 1,0,1,1,0,0,1,0 -> 0xB2, valid one cycle after bit 8
    pif.byte_ready = 1'b1;
    feed_byte(8'hB2, 7);
    check("b2_valid_before", pif.byte_valid, 1'b0);
    exp_q.push_back(8'hB2);
    feed(1'b0);
    check("b2_valid", pif.byte_valid, 1'b1);
    check("b2_out", pif.byte_out, 8'hB2);
    check("b2_rct", rct_fail, 1'b0);
    check("b2_ovr", overrun, 1'b0);
    tick();
    check("b2_valid_after_xfer", pif.byte_valid, 1'b0);

    // eight ones trip the RCT on the 8th bit; 0xFF never presented
    for (int i = 0; i < 7; i++) feed(1'b1);
    check("rct_before_8th", rct_fail, 1'b0);
    feed(1'b1);
    check("rct_at_8th", rct_fail, 1'b1);
    check("rct_byte_dropped", pif.byte_valid, 1'b0);
    tick(); tick();
    check("rct_byte_still_dropped", pif.byte_valid, 1'b0);
    pulse_clr();
    check("rct_cleared", rct_fail, 1'b0);

    // overrun: ready low, 16 alternating bits
    pif.byte_ready = 1'b0;
    exp_q.push_back(8'hAA);
    feed_byte(8'hAA, 8);
    check("aa_valid", pif.byte_valid, 1'b1);
    check("aa_out", pif.byte_out, 8'hAA);
    check("aa_no_ovr_yet", overrun, 1'b0);
    feed_byte(8'hAA, 8);
    check("aa_held", pif.byte_out, 8'hAA);
    check("ovr_set", overrun, 1'b1);
    pif.byte_ready = 1'b1;
    tick();
    check("aa_valid_after_xfer", pif.byte_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);
    pulse_clr();
    check("ovr_cleared", overrun, 1'b0);

    // clear coincident with a bit 1: run of 8 includes that bit
    clr_fail = 1'b1;
    feed(1'b1);
    clr_fail = 1'b0;
    for (int i = 0; i < 6; i++) feed(1'b1);
    check("coinc_rct_6th", rct_fail, 1'b0);
    feed(1'b1);
    check("coinc_rct_7th", rct_fail, 1'b1);
    check("coinc_byte_dropped", pif.byte_valid, 1'b0);
    pulse_clr();
    check("coinc_cleared", rct_fail, 1'b0);

    // reset mid-byte discards partial byte
    feed(1'b1); feed(1'b1); feed(1'b0); feed(1'b1); feed(1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", pif.byte_valid, 1'b0);
    feed_byte(8'h5A, 7);
    exp_q.push_back(8'h5A);
    feed(1'b0);
    check("5a_out", pif.byte_out, 8'h5A);
    check("5a_valid", pif.byte_valid, 1'b1);
    tick();

    // ena low: valid bits ignored
    feed_byte(8'h96, 4);
    ena = 1'b0;
    pif.bit_in = 1'b1; pif.bit_valid = 1'b1;
    tick(); tick(); tick();
    pif.bit_valid = 1'b0;
    ena = 1'b1;
    check("ena_no_byte", pif.byte_valid, 1'b0);
    feed(1'b0); feed(1'b1); feed(1'b1);
    exp_q.push_back(8'h96);
    feed(1'b0);
    check("96_out", pif.byte_out, 8'h96);
    tick();

    // transfer and new byte on the same edge
    pif.byte_ready = 1'b0;
    exp_q.push_back(8'h3C);
    feed_byte(8'h3C, 8);
    check("3c_out", pif.byte_out, 8'h3C);
    feed_byte(8'hC3, 7);
    pif.byte_ready = 1'b1;
    exp_q.push_back(8'hC3);
    feed(1'b1);
    check("c3_valid_kept", pif.byte_valid, 1'b1);
    check("c3_out", pif.byte_out, 8'hC3);
    check("c3_no_ovr", overrun, 1'b0);
    tick();
    check("c3_valid_after_xfer", pif.byte_valid, 1'b0);

    // APT: 48 ones then 16 zeros in one 64-sample window
    apif.byte_ready = 1'b1;
    tick();
    rst2_n = 1'b1;
    for (int i = 0; i < 5; i++) exp2_q.push_back(8'hFF);
    if (!APT_ON) begin
      exp2_q.push_back(8'hFF);
      exp2_q.push_back(8'h00);
      exp2_q.push_back(8'h00);
    end
    for (int i = 0; i < 47; i++) feed_apt(1'b1);
    check("apt_before_48", apt2, 1'b0);
    feed_apt(1'b1);
    check("apt_at_48", apt2, APT_ON);
    for (int i = 0; i < 16; i++) feed_apt(1'b0);
    check("apt_end_window", apt2, APT_ON);
    check("apt_rct", rct2, 1'b0);
    tick(); tick();

    check("main_queue_empty", exp_q.size(), 0);
    check("apt_queue_empty", exp2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
